// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types, trigger-mode codes and helpers for the retirement trace buffer
//
// Contents:
//   trace_state_t : capture FSM encoding (IDLE, ARMED, POST, DONE)
//   TRIG_*        : trig_mode input codes
//   clog2         : elaboration-time ceiling log2 used for address widths
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam logic [1:0] TRIG_CYCLE = 2'd0;
    localparam logic [1:0] TRIG_PC    = 2'd1;
    localparam logic [1:0] TRIG_EXT   = 2'd2;
    localparam logic [1:0] TRIG_NEVER = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace storage, one write port and one registered read port
//
// Ports:
//   clock, resetn : clock and asynchronous active-low reset (clears the read register only)
//   wr_en         : write strobe
//   wr_addr       : write entry address
//   wr_data       : write word
//   rd_addr       : read entry address, sampled every clock
//   rd_data       : registered read word, valid one cycle after rd_addr
module trace_ram
    import trace_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 96,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The array itself has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - circular retirement trace with programmable trigger, post-trigger window and core halt
//
// Ports:
//   clock, resetn        : clock and asynchronous active-low reset
//   arm                  : one-cycle pulse, clears the buffer and starts capture from any state
//   trig_mode            : 0 cycle match, 1 PC match, 2 external, 3 never
//   trig_cycle, trig_pc  : match values for modes 0 and 1
//   ext_trig             : external trigger level for mode 2
//   in_valid             : a real instruction retires this cycle
//   in_pc, in_inst       : retiring PC and instruction
//   halt                 : high once the post-trigger window is complete
//   state                : current capture state
//   count                : valid entries, saturating at DEPTH
//   trig_index           : entry index of the first sample on or after the trigger (DONE only)
//   rd_addr              : read entry, 0 = oldest
//   rd_pc, rd_inst, rd_cycle : read data, one cycle after rd_addr
module trace_buffer
    import trace_pkg::*;
#(
    parameter  int DEPTH     = 64,
    parameter  int POST_TRIG = 32,
    parameter  int CYCLE_W   = 32,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [CYCLE_W-1:0] trig_cycle,
    input  logic [31:0]        trig_pc,
    input  logic               ext_trig,
    input  logic               in_valid,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_inst,
    output logic               halt,
    output logic [1:0]         state,
    output logic [AW:0]        count,
    output logic [AW:0]        trig_index,
    input  logic [AW-1:0]      rd_addr,
    output logic [31:0]        rd_pc,
    output logic [31:0]        rd_inst,
    output logic [CYCLE_W-1:0] rd_cycle
);

    localparam int          WIDTH     = 64 + CYCLE_W;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_INIT = (AW+1)'(POST_TRIG);

    trace_state_t       cur_state;
    trace_state_t       nxt_state;
    logic [CYCLE_W-1:0] cyc;
    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        cnt;
    logic [AW:0]        post_left;
    logic               capturing;
    logic               trig_hit;
    logic               wr_en;
    logic               window_done;
    logic [AW-1:0]      rd_phys;
    logic [WIDTH-1:0]   wr_word;
    logic [WIDTH-1:0]   rd_word;

    assign capturing = (cur_state == ST_ARMED) || (cur_state == ST_POST);

    // arm wins over a coincident write so a restarted capture begins empty.
    assign wr_en = capturing && in_valid && !arm;

    always_comb begin
        trig_hit = 1'b0;
        if (cur_state == ST_ARMED) begin
            case (trig_mode)
                TRIG_CYCLE: trig_hit = (cyc == trig_cycle);
                TRIG_PC:    trig_hit = in_valid && (in_pc == trig_pc);
                TRIG_EXT:   trig_hit = ext_trig;
                default:    trig_hit = 1'b0;
            endcase
        end
    end

    // The window closes on the sample that takes post_left to zero. A valid
    // sample in the trigger cycle already counts, so a one-sample window can
    // finish straight from ARMED.
    always_comb begin
        window_done = 1'b0;
        if (cur_state == ST_ARMED) begin
            window_done = trig_hit && in_valid && (POST_INIT == (AW+1)'(1));
        end else if (cur_state == ST_POST) begin
            window_done = in_valid && (post_left == (AW+1)'(1));
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt_state = cur_state;
        if (arm) begin
            nxt_state = ST_ARMED;
        end else begin
            case (cur_state)
                ST_ARMED: begin
                    if (trig_hit) begin
                        nxt_state = window_done ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (window_done) begin
                        nxt_state = ST_DONE;
                    end
                end
                default: nxt_state = cur_state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        halt       = (cur_state == ST_DONE);
        trig_index = '0;
        if (cur_state == ST_DONE) begin
            trig_index = cnt - POST_INIT;
        end
    end

    assign state = cur_state;
    assign count = cnt;

    // ---------------- capture datapath ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cyc       <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            post_left <= '0;
        end else if (arm) begin
            cyc       <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            post_left <= '0;
        end else begin
            if (capturing) begin
                cyc <= cyc + CYCLE_W'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (cnt != DEPTH_CNT) begin
                    cnt <= cnt + (AW+1)'(1);
                end
            end
            if ((cur_state == ST_ARMED) && trig_hit) begin
                post_left <= POST_INIT - (AW+1)'(in_valid);
            end else if ((cur_state == ST_POST) && in_valid) begin
                post_left <= post_left - (AW+1)'(1);
            end
        end
    end

    assign wr_word = {in_pc, in_inst, cyc};

    // Entry 0 is the oldest sample: count entries back from the write pointer.
    // DEPTH is a power of two, so the AW-bit arithmetic wraps modulo DEPTH.
    assign rd_phys = wr_ptr - cnt[AW-1:0] + rd_addr;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_phys),
        .rd_data (rd_word)
    );

    assign rd_pc    = rd_word[WIDTH-1 -: 32];
    assign rd_inst  = rd_word[CYCLE_W+31 -: 32];
    assign rd_cycle = rd_word[CYCLE_W-1:0];

endmodule
